// File: rtl/mul_div_pkg.sv
// Shared definitions for the MIPS HI/LO multiply/divide unit: funct codes, FSM states, op kinds.
package mul_div_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_kind_t;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Divide datapath is present only when MUL_DIV_DIV_EN is defined.
module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  op_kind_t           op,
  output logic [2*WIDTH-1:0] acc_next
);

  // Multiply: acc = {partial product, remaining multiplier bits}, LSB selects the add.
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;

  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
  assign mul_next = {sum, acc[WIDTH-1:1]};

`ifdef MUL_DIV_DIV_EN
  // Divide: acc = {partial remainder, dividend bits becoming quotient bits}.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;

  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, operand};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
  assign acc_next = (op == OP_DIV) ? div_next : mul_next;
`else
  logic unused_op;
  assign unused_op = op;
  assign acc_next  = mul_next;
`endif

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers (IDLE -> RUN x WIDTH -> FIX).
// Define MUL_DIV_DIV_EN to build the divider; otherwise DIV/DIVU are ignored.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   hi, lo;
  op_kind_t           op_kind;
  logic               neg_main;
  logic               done;

  logic               accept;
  logic               launch;
  logic               launch_div;
  logic               signed_op;
  logic               is_mt_hi;
  logic               is_mt_lo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef MUL_DIV_DIV_EN
  logic               neg_rem;
  logic               div_zero;
  logic               dz_pulse;
  logic [WIDTH-1:0]   raw_a;
  logic [WIDTH-1:0]   quot, rem;
`endif

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .op       (op_kind),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept     = start_i && (state == IDLE);
    is_mt_hi   = accept && (funct_i == FUNCT_MTHI);
    is_mt_lo   = accept && (funct_i == FUNCT_MTLO);
    launch_div = 1'b0;
    signed_op  = (funct_i == FUNCT_MULT);
`ifdef MUL_DIV_DIV_EN
    launch_div = (funct_i == FUNCT_DIV) || (funct_i == FUNCT_DIVU);
    signed_op  = signed_op || (funct_i == FUNCT_DIV);
`endif
    launch = accept && (launch_div || (funct_i == FUNCT_MULT) || (funct_i == FUNCT_MULTU));
    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    mag_a  = (signed_op && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
    mag_b  = (signed_op && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;

    prod   = neg_main ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
`ifdef MUL_DIV_DIV_EN
    quot = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (op_kind == OP_DIV) begin
      fix_lo = div_zero ? '1    : (neg_main ? -quot : quot);
      fix_hi = div_zero ? raw_a : (neg_rem  ? -rem  : rem);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      op_kind  <= OP_MUL;
      neg_main <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
`ifdef MUL_DIV_DIV_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      dz_pulse <= 1'b0;
      raw_a    <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MUL_DIV_DIV_EN
      dz_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (launch) begin
            count    <= '0;
            op_kind  <= launch_div ? OP_DIV : OP_MUL;
            acc      <= {{WIDTH{1'b0}}, (launch_div ? mag_a : mag_b)};
            operand  <= launch_div ? mag_b : mag_a;
            neg_main <= signed_op && (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
`ifdef MUL_DIV_DIV_EN
            neg_rem  <= signed_op && op_a_i[WIDTH-1];
            div_zero <= (op_b_i == '0);
            raw_a    <= op_a_i;
`endif
          end
          if (is_mt_hi) hi <= op_a_i;
          if (is_mt_lo) lo <= op_a_i;
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + 1'b1;
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
`ifdef MUL_DIV_DIV_EN
          dz_pulse <= (op_kind == OP_DIV) && div_zero;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy_o    = (state != IDLE);
  assign done_o    = done;
  assign hi_o      = hi;
  assign lo_o      = lo;
  assign rd_data_o = (funct_i == FUNCT_MFHI) ? hi : lo;
`ifdef MUL_DIV_DIV_EN
  assign div_zero_o = dz_pulse;
`else
  assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model plus hand-computed expectations.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [5:0]    funct_i;
  logic [W-1:0]  op_a_i, op_b_i;
  logic          busy_o, done_o, div_zero_o;
  logic [W-1:0]  hi_o, lo_o, rd_data_o;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .funct_i    (funct_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .rd_data_o  (rd_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result {div_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] up;
    longint      sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = '0;
    case (f)
      FUNCT_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        return {1'b0, up};
      end
      FUNCT_MULT: begin
        p  = sa * sb;
        up = p;
        return {1'b0, up};
      end
      FUNCT_DIVU: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      FUNCT_DIV: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q  = sa / sb;
        r  = sa % sb;
        up = {r[31:0], q[31:0]};
        return {1'b0, up};
      end
      default: return '0;
    endcase
  endfunction

  function automatic bit is_long_op(input logic [5:0] f);
`ifdef MUL_DIV_DIV_EN
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
`else
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
`endif
  endfunction

  int          m_left;
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_dz;
  logic [64:0] m_pend;

  // Result lands W+1 edges after the accept edge; nothing is accepted meanwhile.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
          m_dz   <= m_pend[64];
        end
      end else if (start_i) begin
        if (funct_i == FUNCT_MTHI) m_hi <= op_a_i;
        else if (funct_i == FUNCT_MTLO) m_lo <= op_a_i;
        else if (is_long_op(funct_i)) begin
          m_left <= W + 1;
          m_pend <= model_op(funct_i, op_a_i, op_b_i);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy",     32'(busy_o),     32'(m_left != 0));
      check("done",     32'(done_o),     32'(m_done));
      check("div_zero", 32'(div_zero_o), 32'(m_dz));
      check("hi",       hi_o,            m_hi);
      check("lo",       lo_o,            m_lo);
      check("rd_data",  rd_data_o,       (funct_i == FUNCT_MFHI) ? m_hi : m_lo);
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    funct_i = f;
    op_a_i  = a;
    op_b_i  = b;
    @(posedge clk);
    #2;
    start_i = 1'b0;
    funct_i = 6'b000000;
  endtask

  // Returns at the negedge where done_o is seen; cyc counts negedges since the accept edge.
  task automatic wait_done(input string name, output int cyc, output int busy_cyc, output logic dz);
    bit got;
    got      = 1'b0;
    cyc      = 0;
    busy_cyc = 0;
    dz       = 1'b0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (busy_o) busy_cyc++;
      if (done_o) begin
        got = 1'b1;
        cyc = i;
        dz  = div_zero_o;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done_within_60", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int   cyc, bcyc, ndone;
    logic dz;

    rst = 1'b1; start_i = 1'b0; funct_i = '0; op_a_i = '0; op_b_i = '0;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_dz",   32'(div_zero_o), 32'd0);
    check("rst_hi",   hi_o, 32'd0);
    check("rst_lo",   lo_o, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", cyc, bcyc, dz);
    check("multu_latency", 32'(cyc),  32'd34);
    check("multu_busy",    32'(bcyc), 32'd33);
    check("multu_hi", hi_o, 32'hFFFF_FFFE);
    check("multu_lo", lo_o, 32'h0000_0001);

    issue(FUNCT_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg", cyc, bcyc, dz);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFF1);
    start_i = 1'b1; funct_i = FUNCT_MFLO;
    #1 check("mflo_rd", rd_data_o, 32'hFFFF_FFF1);
    funct_i = FUNCT_MFHI;
    #1 check("mfhi_rd", rd_data_o, 32'hFFFF_FFFF);
    @(posedge clk); #2;
    start_i = 1'b0; funct_i = '0;

`ifdef MUL_DIV_DIV_EN
    issue(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", cyc, bcyc, dz);
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);
    check("div_dz", 32'(dz), 32'd0);
    issue(FUNCT_DIVU, 32'd7, 32'd0);
    wait_done("divu_zero", cyc, bcyc, dz);
    check("divz_latency", 32'(cyc), 32'd34);
    check("divz_lo", lo_o, 32'hFFFF_FFFF);
    check("divz_hi", hi_o, 32'd7);
    check("divz_dz", 32'(dz), 32'd1);
    issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", cyc, bcyc, dz);
    check("ovf_lo", lo_o, 32'h8000_0000);
    check("ovf_hi", hi_o, 32'd0);
    check("ovf_dz", 32'(dz), 32'd0);
`else
    issue(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    check("nodiv_busy", 32'(busy_o), 32'd0);
    check("nodiv_hi", hi_o, 32'hFFFF_FFFF);
    check("nodiv_lo", lo_o, 32'hFFFF_FFF1);
    repeat (3) @(negedge clk);
`endif
    @(posedge clk); #2;

    issue(FUNCT_MTLO, 32'h0000_1234, 32'd0);
    @(negedge clk);
    check("mtlo_lo",   lo_o, 32'h0000_1234);
    check("mtlo_done", 32'(done_o), 32'd0);
    check("mtlo_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #2;

    issue(FUNCT_MULT, 32'd2, 32'd3);
    repeat (5) @(negedge clk);
    issue(FUNCT_MTHI, 32'h0000_AAAA, 32'd0);
    @(negedge clk);
`ifdef MUL_DIV_DIV_EN
    check("mthi_busy_hi", hi_o, 32'd0);
`else
    check("mthi_busy_hi", hi_o, 32'hFFFF_FFFF);
`endif
    wait_done("mult_small", cyc, bcyc, dz);
    check("small_hi", hi_o, 32'd0);
    check("small_lo", lo_o, 32'd6);
    issue(FUNCT_MULTU, 32'd7, 32'd8);
    @(negedge clk);
    check("b2b_accept", 32'(busy_o), 32'd1);
    wait_done("mult_b2b", cyc, bcyc, dz);
    check("b2b_latency", 32'(cyc), 32'd33);
    check("b2b_lo", lo_o, 32'd56);

    issue(FUNCT_MULT, 32'd5, 32'd5);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_hi",   hi_o, 32'd0);
    check("midrst_lo",   lo_o, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    issue(FUNCT_MULTU, 32'd3, 32'd4);
    wait_done("multu_after_rst", cyc, bcyc, dz);
    check("post_rst_lo", lo_o, 32'd12);
    check("post_rst_hi", hi_o, 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS execute stage. It decodes the R-type funct field (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO), runs iterative shift-add multiplication or restoring division over WIDTH cycles, and holds the results in HI/LO. It sits beside the ALU in EX; the pipeline control stalls on `busy_o`.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width (≥4); iteration counter width is $clog2(WIDTH+1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  R-type instruction valid in EX (isRType qualified)
- funct_i  in  6  R-type funct field
- op_a_i  in  WIDTH  rs value (dividend / multiplicand / MT source)
- op_b_i  in  WIDTH  rt value (divisor / multiplier)
- busy_o  out  1  operation in progress; new starts ignored
- done_o  out  1  one-cycle pulse; HI/LO hold the new result
- div_zero_o  out  1  pulses with done_o when the divisor was 0
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register
- rd_data_o  out  WIDTH  combinational: hi_o when funct_i=MFHI, else lo_o

## Operation

- Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. Any other funct: no effect.
- An op is accepted on a rising edge where start_i=1 and busy_o=0.
- MTHI/MTLO: HI or LO ← op_a_i at the accept edge. No busy_o, no done_o.
- MFHI/MFLO: no state change. The pipeline must not issue them while busy_o=1.
- MULT/DIV family:
  - At accept, capture the operand magnitudes (signed ops take the absolute value; −2^(WIDTH−1) maps to unsigned 2^(WIDTH−1)), the two sign bits, the op kind, and divisor==0.
- States:
  - IDLE → RUN on accept.
  - RUN lasts exactly WIDTH cycles:
    - Multiply: one shift-add step per cycle into a 2·WIDTH accumulator.
    - Divide: one restoring shift-subtract step per cycle.
  - RUN → FIX after WIDTH cycles.
  - FIX → IDLE after one cycle. FIX applies sign correction and writes HI/LO.
- Sign rules (signed ops only):
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - −2^(WIDTH−1) ÷ −1 gives LO=0x8000_0000, HI=0 (wraps, no trap).
- Divide by zero: LO=all ones, HI=op_a_i (raw value as captured), div_zero_o=1. Runs the full latency.
- rst asserted at any time:
  - State → IDLE.
  - HI=LO=0.
  - busy_o=done_o=div_zero_o=0 immediately.
  - In-flight op discarded.

## Timing

- Reset values: busy_o=0, done_o=0, div_zero_o=0, hi_o=0, lo_o=0.
- Accept at edge E0.
  - busy_o=1 from E0 through the edge closing FIX (WIDTH+1 cycles).
  - At edge E(WIDTH+1): HI/LO updated, done_o=1 for one cycle, busy_o=0.
- Start-to-done latency: WIDTH+1 edges. For WIDTH=32, done_o is seen in the 34th cycle counting the accept cycle as 1.
- A start in the done_o cycle is accepted (back-to-back ops).
- A start while busy_o=1 is ignored entirely, including MT*.
- MT* accept: new value is visible on hi_o/lo_o the cycle after the edge.

## Configuration

- MUL_DIV_DIV_EN defined: DIV/DIVU are supported as above.
- MUL_DIV_DIV_EN undefined:
  - No divider logic.
  - DIV/DIVU are treated as unknown funct: no busy_o, no done_o, HI/LO unchanged.
  - div_zero_o tied to 0.

## Structure

- Package mul_div_pkg holds:
  - funct localparams (FUNCT_MFHI … FUNCT_DIVU)
  - state enum typedef (IDLE, RUN, FIX)
  - op-kind enum (OP_MUL, OP_DIV)
- Sub-module mul_div_step: combinational single iteration. Given the accumulator, operand, and op kind, it returns the next accumulator. It is shared by multiply and divide. mul_div_unit instantiates it once and owns the FSM, counter, sign fix and HI/LO.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; busy_o high 33 cycles, done_o pulse WIDTH+1 edges after accept.
- MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; immediate MFLO → rd_data_o=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 ÷ 0 → LO=0xFFFFFFFF, HI=7, div_zero_o=1 with done_o.
- DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0, div_zero_o=0.
- MTHI 0xAAAA while busy → ignored, HI unchanged. MTLO 0x1234 while idle → lo_o=0x1234 next cycle, no done_o. MULT started in the done_o cycle → accepted.
- rst pulsed 10 cycles into MULT → busy_o=0, hi_o=lo_o=0 before the next edge, no done_o. MULTU 3×4 after release → LO=12.
